// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing a - b, LSB first,
// one full-subtractor step per clock with the borrow carried in a flip-flop.
// A start/busy/done handshake frames each operation; diff and borrow_out are
// held from one completion until the next.
// Optional build macro SERIAL_SUB_SIGNED_EN adds an 'overflow' output that
// reports two's-complement signed overflow of the completed subtraction.

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_SIGNED_EN
   output logic             overflow,
`endif
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             w_busy;
   logic             w_done;

   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   // Holds the WIDTH-1 most recently produced bits; the final bit completes it.
   logic [WIDTH-2:0] r_res;
   logic             r_borrow;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_diff;
   logic             r_borrow_out;
`ifdef SERIAL_SUB_SIGNED_EN
   logic             r_overflow;
`endif

   logic             w_d;
   logic             w_bout;
   logic [WIDTH-1:0] w_res_full;
   logic             w_last;

   // Full-subtractor step on the current LSBs and the registered borrow.
   assign w_d        = r_sa[0] ^ r_sb[0] ^ r_borrow;
   assign w_bout     = (~r_sa[0] & r_sb[0]) | (~r_sa[0] & r_borrow) | (r_sb[0] & r_borrow);
   assign w_res_full = {w_d, r_res};
   assign w_last     = (r_cnt == LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs; a start in DONE chains straight into SHIFT.
   always_comb begin
      w_state_next = r_state;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state_next = SHIFT;
            end
         end
         SHIFT: begin
            w_busy = 1'b1;
            if (w_last) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            w_done = 1'b1;
            if (start) begin
               w_state_next = SHIFT;
            end else begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // Operand capture, bit-serial datapath and result/borrow holding registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sa         <= '0;
         r_sb         <= '0;
         r_res        <= '0;
         r_borrow     <= 1'b0;
         r_cnt        <= '0;
         r_diff       <= '0;
         r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
         r_overflow   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               // Operands are sampled only here, so start during SHIFT is ignored.
               if (start) begin
                  r_sa     <= a;
                  r_sb     <= b;
                  r_borrow <= 1'b0;
                  r_cnt    <= '0;
               end
            end
            SHIFT: begin
               r_sa     <= r_sa >> 1;
               r_sb     <= r_sb >> 1;
               r_res    <= w_res_full[WIDTH-1:1];
               r_borrow <= w_bout;
               r_cnt    <= r_cnt + CW'(1);
               if (w_last) begin
                  r_diff       <= w_res_full;
                  r_borrow_out <= w_bout;
`ifdef SERIAL_SUB_SIGNED_EN
                  // Borrow into the sign bit differing from borrow out of it
                  // means the signed result left the representable range.
                  r_overflow   <= r_borrow ^ w_bout;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy       = w_busy;
   assign done       = w_done;
   assign diff       = r_diff;
   assign borrow_out = r_borrow_out;
`ifdef SERIAL_SUB_SIGNED_EN
   assign overflow   = r_overflow;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed 8-bit vectors with hand-computed
// results, handshake and reset cases, and an exhaustive sweep of a 4-bit instance.

module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst;

   logic       start8;
   logic [7:0] a8, b8;
   logic       busy8, done8, bo8;
   logic [7:0] diff8;

   logic       start4;
   logic [3:0] a4, b4;
   logic       busy4, done4, bo4;
   logic [3:0] diff4;

`ifdef SERIAL_SUB_SIGNED_EN
   logic       ov8, ov4;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .start      (start8),
      .a          (a8),
      .b          (b8),
      .busy       (busy8),
      .done       (done8),
      .diff       (diff8),
`ifdef SERIAL_SUB_SIGNED_EN
      .overflow   (ov8),
`endif
      .borrow_out (bo8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .start      (start4),
      .a          (a4),
      .b          (b4),
      .busy       (busy4),
      .done       (done4),
      .diff       (diff4),
`ifdef SERIAL_SUB_SIGNED_EN
      .overflow   (ov4),
`endif
      .borrow_out (bo4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at the first negedge after the accept edge; counts clocks until done.
   task automatic wait_done8(output int cyc);
      cyc = 0;
      while (done8 !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] ed, input logic eb, input string tag);
      int cyc;
      @(negedge clk);
      start8 = 1'b1; a8 = av; b8 = bv;
      @(negedge clk);
      start8 = 1'b0; a8 = ~av; b8 = ~bv;
      check({tag, "_busy"}, 32'(busy8), 32'd1);
      wait_done8(cyc);
      check({tag, "_latency"}, 32'(cyc), 32'd8);
      check({tag, "_diff"}, 32'(diff8), 32'(ed));
      check({tag, "_borrow"}, 32'(bo8), 32'(eb));
      check({tag, "_busy_at_done"}, 32'(busy8), 32'd0);
      $display("op %s: a=0x%02h b=0x%02h diff=0x%02h borrow=%0d latency=%0d",
               tag, av, bv, diff8, bo8, cyc);
   endtask

   initial begin
      int cyc;
      rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; a4 = '0; b4 = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_diff", 32'(diff8), 32'd0);
      check("rst_borrow", 32'(bo8), 32'd0);
      check("rst4_diff", 32'(diff4), 32'd0);
`ifdef SERIAL_SUB_SIGNED_EN
      check("rst_overflow", 32'(ov8), 32'd0);
`endif
      rst = 1'b0;

      // Basic and borrow/wrap cases
      op8(8'h05, 8'h03, 8'h02, 1'b0, "basic_5_3");
`ifdef SERIAL_SUB_SIGNED_EN
      check("ovf_5_3", 32'(ov8), 32'd0);
`endif
      op8(8'h03, 8'h05, 8'hFE, 1'b1, "wrap_3_5");
      op8(8'h00, 8'hFF, 8'h01, 1'b1, "wrap_0_ff");
      op8(8'h00, 8'h00, 8'h00, 1'b0, "zero");
`ifdef SERIAL_SUB_SIGNED_EN
      op8(8'h80, 8'h01, 8'h7F, 1'b0, "sgn_80_01");
      check("ovf_80_01", 32'(ov8), 32'd1);
      op8(8'h7F, 8'hFF, 8'h80, 1'b1, "sgn_7f_ff");
      check("ovf_7f_ff", 32'(ov8), 32'd1);
`endif

      // start held through SHIFT while operands change: first result unaffected
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h40; b8 = 8'h10;
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'h01;
      check("hold_busy", 32'(busy8), 32'd1);
      wait_done8(cyc);
      start8 = 1'b0;
      check("hold_latency", 32'(cyc), 32'd8);
      check("hold_diff", 32'(diff8), 32'h30);
      check("hold_borrow", 32'(bo8), 32'd0);
      $display("op hold_start: a=0x40 b=0x10 diff=0x%02h latency=%0d", diff8, cyc);
      @(negedge clk);
      check("hold_idle_busy", 32'(busy8), 32'd0);
      check("hold_idle_done", 32'(done8), 32'd0);

      // start in the DONE cycle chains a second operation with no bubble
      op8(8'h05, 8'h03, 8'h02, 1'b0, "chain_first");
      start8 = 1'b1; a8 = 8'h10; b8 = 8'h01;
      @(negedge clk);
      start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      check("chain_busy", 32'(busy8), 32'd1);
      check("chain_done_low", 32'(done8), 32'd0);
      check("chain_diff_held", 32'(diff8), 32'h02);
      wait_done8(cyc);
      check("chain_latency", 32'(cyc), 32'd8);
      check("chain_diff", 32'(diff8), 32'h0F);
      check("chain_borrow", 32'(bo8), 32'd0);
      $display("op chain_second: a=0x10 b=0x01 diff=0x%02h latency=%0d", diff8, cyc);

      // Reset mid-operation discards it and clears outputs
      @(negedge clk);
      start8 = 1'b1; a8 = 8'h80; b8 = 8'h01;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy8), 32'd0);
      check("midrst_done", 32'(done8), 32'd0);
      check("midrst_diff", 32'(diff8), 32'd0);
      check("midrst_borrow", 32'(bo8), 32'd0);
      $display("op midrst: reset during a=0x80 b=0x01");
      op8(8'h80, 8'h01, 8'h7F, 1'b0, "after_rst");

      // Exhaustive 4-bit sweep
      for (int i = 0; i < 256; i++) begin
         logic [3:0] av, bv, ed;
         int         c4;
         av = 4'(i >> 4);
         bv = 4'(i);
         ed = av - bv;
         @(negedge clk);
         start4 = 1'b1; a4 = av; b4 = bv;
         @(negedge clk);
         start4 = 1'b0; a4 = ~av;
         c4 = 0;
         while (done4 !== 1'b1 && c4 < 20) begin
            @(negedge clk);
            c4++;
         end
         check("ex4_latency", 32'(c4), 32'd4);
         check("ex4_diff", 32'(diff4), 32'(ed));
         check("ex4_borrow", 32'(bo4), 32'(av < bv));
`ifdef SERIAL_SUB_SIGNED_EN
         begin
            int sd;
            sd = int'($signed(av)) - int'($signed(bv));
            check("ex4_overflow", 32'(ov4), 32'((sd < -8) || (sd > 7)));
         end
`endif
         $display("op ex4: a=0x%0h b=0x%0h diff=0x%0h borrow=%0d latency=%0d",
                  av, bv, diff4, bo4, c4);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor that computes a - b, one bit per clock, LSB first.
- Each cycle applies one full-subtractor step: diff = a^b^bin, bout = (~a&b)|(~a&bin)|(b&bin). The borrow is registered between cycles.
- Start/busy/done handshake; the result is held until the next operation.
- Trades latency for area compared with a ripple array of full subtractors.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a subtraction; sampled on the rising edge of clk.
- a  input  WIDTH  minuend; captured on the start-accept edge.
- b  input  WIDTH  subtrahend; captured on the start-accept edge.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when diff and borrow_out are valid.
- diff  output  WIDTH  result a - b modulo 2^WIDTH; held until the next accept.
- borrow_out  output  1  final borrow; 1 when a < b unsigned.

Behaviour:
- States: IDLE, SHIFT, DONE. Registers:
  - shift registers sa and sb.
  - result shift register.
  - borrow flip-flop.
  - bit counter of clog2(WIDTH+1) bits.
- Reset (rst=1 on a clock edge):
  - state=IDLE; busy=0; done=0; diff=0; borrow_out=0; borrow=0; counter=0.
  - Applies from any state; an in-flight operation is discarded.
- IDLE or DONE with start=1 at edge k:
  - load sa=a, sb=b, borrow=0, counter=0.
  - state=SHIFT, busy=1, done=0.
  - diff and borrow_out keep their previous values until completion.
- SHIFT, at each edge:
  - d = sa[0]^sb[0]^borrow.
  - borrow <= (~sa[0]&sb[0])|(~sa[0]&borrow)|(sb[0]&borrow).
  - shift d into the result MSB (the result shifts right); sa and sb shift right; counter += 1.
- Last bit (counter==WIDTH-1) at edge k+WIDTH:
  - diff <= completed result; borrow_out <= final borrow.
  - state=DONE, busy=0, done=1.
- Latency: done is high in the cycle following edge k+WIDTH, i.e. WIDTH clocks after accept.
- DONE at the next edge:
  - done=0.
  - state=IDLE, or SHIFT if start=1 (back-to-back operation, no bubble).
- start while in SHIFT: ignored; no queuing, and the a/b inputs are not sampled.
- a and b may change freely after the accept edge without affecting the result.
- Wrap-around: the result is modulo 2^WIDTH; e.g. 0 - 1 gives all ones with borrow_out=1.
- IDLE with start=0: all outputs hold.

Optional Feature:
- Macro SERIAL_SUB_SIGNED_EN.
- When defined:
  - extra port overflow (output, 1 bit), reset to 0.
  - On completion, overflow <= borrow into the MSB step XOR the final borrow, which is the two's-complement signed overflow of a - b.
  - Updated at the same edge as diff and held with it.
- When undefined: no overflow port or logic; all other behaviour is identical.

Test Plan:
- Basic: WIDTH=8, a=5, b=3, start one cycle -> busy for 8 cycles, done pulse, diff=0x02, borrow_out=0.
- Borrow and wrap:
  - a=3, b=5 -> diff=0xFE, borrow_out=1.
  - a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
  - a=0, b=0 -> diff=0x00, borrow_out=0.
- Handshake:
  - start held high through SHIFT with a/b changed mid-operation -> first result is unaffected (a=0x40, b=0x10 gives 0x30).
  - start high in the DONE cycle -> second operation starts with no idle cycle.
- Reset mid-operation: rst=1 at bit 4 of a=0x80, b=0x01 -> next cycle busy=0, done=0, diff=0, borrow_out=0; a new start afterwards gives the correct 0x7F.
- Signed (SERIAL_SUB_SIGNED_EN):
  - a=0x80, b=0x01 -> diff=0x7F, overflow=1.
  - a=0x05, b=0x03 -> overflow=0.
  - a=0x7F, b=0xFF -> diff=0x80, overflow=1.
- Exhaustive at WIDTH=4: all 256 pairs of a and b -> diff==(a-b)&0xF and borrow_out==(a<b), each with done after exactly 4 cycles.
